// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/load producers, the issue stage and the
// register-file write-back arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              RegWrite;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  logic [2**ADDR_W-1:0] busy;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    output issue_valid, issue_rd,
    input  a_ready, b_ready,
    input  RegWrite, RD, WriteData, busy
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    input  issue_valid, issue_rd,
    output a_ready, b_ready,
    output RegWrite, RD, WriteData, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port,
// with a per-register pending-write busy vector for hazard stalls.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {GNT_A, GNT_B} grant_t;

  grant_t            r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wd;
  logic [NREG-1:0]   r_busy;

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_xfer;
  logic              w_wr;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_wd;
  logic [NREG-1:0]   w_busy_nxt;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
        w_gnt_a = (r_last == GNT_B);
        w_gnt_b = (r_last == GNT_A);
      end else begin
        w_gnt_a = bus.a_valid;
        w_gnt_b = bus.b_valid;
      end
    end
  end

  assign w_xfer = w_gnt_a | w_gnt_b;
  assign w_rd   = w_gnt_b ? bus.b_rd : bus.a_rd;
  assign w_wd   = w_gnt_b ? bus.b_data : bus.a_data;
  assign w_wr   = w_xfer && (w_rd != '0);

  // Set is applied after clear so a same-cycle reissue stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)
      w_busy_nxt[w_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0))
      w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= GNT_B;
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_wd   <= '0;
      r_busy <= '0;
    end else begin
      r_we   <= w_wr;
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_rd   <= w_rd;
        r_wd   <= w_wd;
        r_last <= w_gnt_b ? GNT_B : GNT_A;
      end
    end
  end

  assign bus.a_ready   = w_gnt_a;
  assign bus.b_ready   = w_gnt_b;
  assign bus.RegWrite  = r_we;
  assign bus.RD        = r_rd;
  assign bus.WriteData = r_wd;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed and random traffic, with a
// per-cycle expected-output queue drained by an independent monitor.
module tb_regfile_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
    logic [NR-1:0] busy;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  bit            m_a_turn = 1'b1;
  bit            m_busy[NR];
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_wd = '0;
  bit            last_ga;
  bit            last_gb;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t          e;
    bit            ga;
    bit            gb;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (!reset) begin
      if (bus.a_valid && (!bus.b_valid || m_a_turn)) ga = 1'b1;
      else if (bus.b_valid) gb = 1'b1;
    end
    chk("a_ready", bus.a_ready, ga);
    chk("b_ready", bus.b_ready, gb);
    e.we = 1'b0;
    if (reset) begin
      m_a_turn = 1'b1;
      for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      if (ga || gb) begin
        rd = ga ? bus.a_rd : bus.b_rd;
        wd = ga ? bus.a_data : bus.b_data;
        e.we = (rd != 0);
        m_rd = rd;
        m_wd = wd;
        if (rd != 0) m_busy[rd] = 1'b0;
        m_a_turn = gb;
      end
      if (bus.issue_valid && bus.issue_rd != 0)
        m_busy[bus.issue_rd] = 1'b1;
    end
    e.rd = m_rd;
    e.wd = m_wd;
    for (int i = 0; i < NR; i++) e.busy[i] = m_busy[i];
    expq.push_back(e);
    last_ga = ga;
    last_gb = gb;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output with no expectation at %0t", $time);
      end else begin
        e = expq.pop_front();
        chk("RegWrite", bus.RegWrite, e.we);
        chk("RD", bus.RD, e.rd);
        chk("WriteData", bus.WriteData, e.wd);
        chk("busy", bus.busy, e.busy);
      end
    end
  end

  task automatic idle();
    bus.a_valid     = 1'b0;
    bus.b_valid     = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin : driver
    reset           = 1'b1;
    bus.a_rd        = '0;
    bus.a_data      = '0;
    bus.b_rd        = '0;
    bus.b_data      = '0;
    bus.issue_rd    = '0;
    idle();
    do_reset();

    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd5;
    bus.a_data  = 64'h1234;
    step();
    idle();
    step();
    step();

    do_reset();
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd3;
    bus.a_data  = 64'hA3;
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd7;
    bus.b_data  = 64'hB7;
    repeat (4) step();
    idle();
    step();

    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    step();
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd9;
    bus.b_data  = 64'h99;
    step();
    bus.issue_valid = 1'b0;
    bus.b_data      = 64'h9A;
    step();
    idle();
    step();

    bus.a_valid     = 1'b1;
    bus.a_rd        = 5'd0;
    bus.a_data      = 64'hFF;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    step();
    idle();
    step();

    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd12;
    step();
    idle();
    bus.a_valid = 1'b1;
    bus.a_rd    = 5'd12;
    bus.a_data  = 64'hC12;
    step();
    bus.b_valid = 1'b1;
    bus.b_rd    = 5'd13;
    bus.b_data  = 64'hD13;
    bus.a_rd    = 5'd14;
    bus.a_data  = 64'hE14;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    idle();
    step();

    for (int n = 0; n < 600; n++) begin
      if (bus.a_valid && last_ga) bus.a_valid = 1'b0;
      if (bus.b_valid && last_gb) bus.b_valid = 1'b0;
      if (!bus.a_valid && ($urandom_range(0, 2) != 0)) begin
        bus.a_valid = 1'b1;
        bus.a_rd    = AW'($urandom_range(0, NR - 1));
        bus.a_data  = {$urandom(), $urandom()};
      end
      if (!bus.b_valid && ($urandom_range(0, 2) != 0)) begin
        bus.b_valid = 1'b1;
        bus.b_rd    = AW'($urandom_range(0, NR - 1));
        bus.b_data  = {$urandom(), $urandom()};
      end
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_rd    = AW'($urandom_range(0, NR - 1));
      reset = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32×64 integer register file. Shares the file's single write port between two producers, the ALU result path (A) and the load-data path (B), using fair round-robin. Presents one registered write per cycle on the file's RegWrite/RD/WriteData inputs. Keeps a per-register busy vector, set at issue and cleared at write-back, so the decode stage can stall on read-after-write hazards.

## Interface
- DATA_W, 64, write-data width
- ADDR_W, 5, register index width (2^ADDR_W registers)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- a_valid  in  1  ALU write-back request
- a_rd  in  ADDR_W  ALU destination index
- a_data  in  DATA_W  ALU result
- a_ready  out  1  ALU request accepted this cycle
- b_valid  in  1  load write-back request
- b_rd  in  ADDR_W  load destination index
- b_data  in  DATA_W  load data
- b_ready  out  1  load request accepted this cycle
- issue_valid  in  1  instruction with a destination issued this cycle
- issue_rd  in  ADDR_W  its destination index
- RegWrite  out  1  register-file write enable (registered)
- RD  out  ADDR_W  register-file write index (registered)
- WriteData  out  DATA_W  register-file write data (registered)
- busy  out  2^ADDR_W  bit i = write to register i pending (registered)

## Operation
- Handshake: a request transfers in a cycle where valid && ready. A requester holds valid, rd and data stable until ready.
- The output stage reloads every cycle, so at least one requester is accepted whenever any is valid. No backpressure exists from the register file.
- Grant rules:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the side opposite last_grant.
- last_grant updates only on an accepted transfer. Reset sets last_grant = B, so A wins the first contest.
- a_ready and b_ready are combinational from the valids and last_grant. Both are 0 while reset is high.
- Output stage, next posedge after a transfer:
  - RegWrite = 1 if the accepted rd ≠ 0, else 0. Writes to x0 are accepted and discarded.
  - RD and WriteData load the accepted rd and data.
- No transfer: RegWrite = 0; RD and WriteData hold their previous values.
- Scoreboard, evaluated per posedge:
  - Clear: an accepted transfer with rd ≠ 0 clears busy[rd].
  - Set: issue_valid with issue_rd ≠ 0 sets busy[issue_rd].
  - Both target the same index in one cycle: set wins (the newer producer is still outstanding).
  - busy[0] is always 0.
  - Issuing to an already-busy register keeps it busy. No count is kept; the issuing stage guarantees no WAW overlap.
- Write-back to a register that is not busy is legal: the write happens and busy stays 0.

## Timing
- Reset values: RegWrite 0, RD 0, WriteData 0, busy all 0, last_grant B, a_ready/b_ready 0.
- Latency: transfer in cycle N → RegWrite/RD/WriteData valid from posedge N+1 for one full cycle. The register file commits on the following negedge.
- busy updates at the same posedge N+1. In cycle N+1 a reader sees busy[rd] = 0 together with RD/WriteData still on the port.
- Throughput: one write per cycle sustained. With both sides valid continuously, grants strictly alternate A, B, A, B…
- Reset mid-operation:
  - Any request present in the reset cycle is not accepted.
  - The output stage clears, so a pending write is dropped.
  - busy clears.
  - Arbitration restarts with A priority.

## Test plan
- Reset, then a_valid=1, a_rd=5, a_data=0x1234 for one cycle → a_ready=1 that cycle. Next cycle RegWrite=1, RD=5, WriteData=0x1234; following cycle RegWrite=0, RD=5 held.
- a_valid and b_valid both high for 4 cycles (a_rd=3, b_rd=7) → a_ready pattern 1,0,1,0 and b_ready 0,1,0,1. RD sequence 3,7,3,7, one cycle delayed. The first grant after reset goes to A.
- issue_valid with issue_rd=9 → busy[9]=1 next cycle. Then a B write to rd=9 while issue_valid with issue_rd=9 in the same cycle → busy[9] stays 1. Then a lone B write to rd=9 → busy[9]=0.
- a_valid with a_rd=0, a_data=0xFF → a_ready=1, next-cycle RegWrite=0. issue_rd=0 → busy[0] remains 0.
- Accept a write to rd=12 while busy[12]=1, and assert reset in the following cycle → RegWrite=0, busy=0, ready=0 during reset. After reset deasserts with both valid, A is granted first.
